gpr_wb_arbiter: RTL

- Shares the register file's single write port between the in-order pipeline write-back stage and the multi-cycle MUL/DIV unit (MDU).
- The pipeline always wins. MDU results wait in a small FIFO and drain in idle write-back slots.
- Keeps a per-register pending mask so decode can stall on RAW/WAW hazards against in-flight MDU ops.
- Sits between the WB stage / MDU and regfile; its busy mask feeds the decode hazard unit.

---
 rtl/gpr_wb_arbiter_pkg.sv | 34 +++
 rtl/gpr_wb_arbiter_wb_fifo.sv | 91 +++++++++
 rtl/gpr_wb_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter_pkg
// Shared types and constants for the GPR write-back arbiter slice.
//   REG_NUM    : number of architectural GPRs
//   regaddr_t  : 5-bit register index
//   word_t     : 32-bit data word
//   bit_t      : single control bit
//   wb_req_t   : {we, waddr, wdata} write request. It is used for the pipeline
//                request, the MDU FIFO entries and the regfile output bundle.
// -----------------------------------------------------------------------------
package gpr_wb_arbiter_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int XLEN    = 32;

  typedef logic              bit_t;
  typedef logic [REG_AW-1:0] regaddr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef struct packed {
    bit_t     we;
    regaddr_t waddr;
    word_t    wdata;
  } wb_req_t;

  localparam wb_req_t WB_REQ_IDLE = '{we: 1'b0, waddr: 5'd0, wdata: 32'd0};

  // A write to x0 has no architectural effect, so it never counts as a write.
  function automatic bit_t is_eff_write(input bit_t we, input regaddr_t waddr);
    return we && (waddr != 5'd0);
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_wb_fifo.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter_wb_fifo
// Small synchronous FIFO that buffers MDU write-back requests.
// Ports:
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push, din: enqueue din. Ignored when full unless a pop happens in the same cycle.
//   pop      : dequeue the head entry. Ignored when empty.
//   head     : current head entry (valid when !empty)
//   count    : number of stored entries (0..DEPTH)
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two >= 2, so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module gpr_wb_arbiter_wb_fifo
  import gpr_wb_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_req_t          din,
  input  logic             pop,
  output wb_req_t          head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic             do_push_s, do_pop_s;

  assign empty = (count_q == CNT_W'(0));
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop frees the head slot, so a push into a full FIFO is allowed in the same cycle.
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (rst) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = WB_REQ_IDLE;
      end
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers. The reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// -----------------------------------------------------------------------------
// gpr_wb_arbiter
// Shares the regfile's single write port between the in-order pipeline WB stage
// and the multi-cycle MUL/DIV unit. The pipeline always wins. MDU results are
// buffered and drain in idle write-back slots. A per-register busy mask tracks
// in-flight MDU destinations for the decode hazard unit.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   pipe_we/pipe_waddr/pipe_wdata    : pipeline write-back request (never stalled)
//   mdu_issue/mdu_issue_waddr        : MDU op dispatched, sets its busy bit
//   mdu_valid/mdu_waddr/mdu_wdata    : MDU result, accepted when mdu_ready
//   mdu_ready                        : registered "FIFO has room"
//   gpr_we/gpr_waddr/gpr_wdata       : regfile write port (combinational mux)
//   busy_mask                        : bit i set while GPR i awaits an MDU write
//   stall_req                        : ask the pipeline for a write-back bubble
// -----------------------------------------------------------------------------
module gpr_wb_arbiter #(
  parameter int REG_NUM      = gpr_wb_arbiter_pkg::REG_NUM,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pipe_we,
  input  logic [4:0]         pipe_waddr,
  input  logic [31:0]        pipe_wdata,
  input  logic               mdu_issue,
  input  logic [4:0]         mdu_issue_waddr,
  input  logic               mdu_valid,
  output logic               mdu_ready,
  input  logic [4:0]         mdu_waddr,
  input  logic [31:0]        mdu_wdata,
  output logic               gpr_we,
  output logic [4:0]         gpr_waddr,
  output logic [31:0]        gpr_wdata,
  output logic [REG_NUM-1:0] busy_mask,
  output logic               stall_req
);

  import gpr_wb_arbiter_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wb_req_t          pipe_req_s;
  wb_req_t          mdu_req_s;
  wb_req_t          fifo_head_s;
  wb_req_t          gpr_req_s;
  bit_t             pw_s;
  bit_t             drain_s;
  bit_t             push_s;
  bit_t             fifo_full_s;
  bit_t             fifo_empty_s;
  logic [CNT_W-1:0] fifo_count_s;
  logic [CNT_W-1:0] count_nxt_s;

  logic               mdu_ready_q, mdu_ready_d;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               stall_q, stall_d;

  assign pipe_req_s = '{we: pipe_we, waddr: pipe_waddr, wdata: pipe_wdata};
  // Entries for x0 are kept so the FIFO stays in order. Their we bit is cleared so the drain only pops.
  assign mdu_req_s  = '{we: (mdu_waddr != 5'd0), waddr: mdu_waddr, wdata: mdu_wdata};

  assign pw_s    = is_eff_write(pipe_we, pipe_waddr);
  assign drain_s = !rst && !pw_s && !fifo_empty_s;
  // mdu_ready_q already excludes a full FIFO. The full term keeps the FIFO safe even if that ever drifts.
  assign push_s  = !rst && mdu_valid && mdu_ready_q && !fifo_full_s;

  gpr_wb_arbiter_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (mdu_req_s),
    .pop   (drain_s),
    .head  (fifo_head_s),
    .count (fifo_count_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Write-port mux: pipeline first, then the FIFO head, otherwise idle.
  always_comb begin
    gpr_req_s = WB_REQ_IDLE;
    if (rst) begin
      gpr_req_s = WB_REQ_IDLE;
    end else if (pw_s) begin
      gpr_req_s = pipe_req_s;
    end else if (drain_s) begin
      gpr_req_s = fifo_head_s;
    end else begin
      gpr_req_s = WB_REQ_IDLE;
    end
  end

  assign gpr_we    = gpr_req_s.we;
  assign gpr_waddr = gpr_req_s.waddr;
  assign gpr_wdata = gpr_req_s.wdata;

  // Ready comes from next-cycle occupancy. A pop therefore frees a slot only from the following cycle.
  always_comb begin
    count_nxt_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(drain_s);
    mdu_ready_d = 1'b0;
    if (rst) begin
      mdu_ready_d = 1'b0;
    end else begin
      mdu_ready_d = (count_nxt_s < CNT_W'(FIFO_DEPTH));
    end
  end

  // Pending-write scoreboard: clear on drain, then set on issue so that set wins.
  always_comb begin
    busy_d = busy_q;
    if (rst) begin
      busy_d = '0;
    end else begin
      if (drain_s) begin
        busy_d[fifo_head_s.waddr] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (mdu_issue && (mdu_issue_waddr != 5'd0)) begin
        busy_d[mdu_issue_waddr] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
  end

  // Starvation counter: counts cycles the head is blocked by the pipeline, and saturates at the limit.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (rst) begin
      starve_d = STV_W'(0);
    end else if (fifo_empty_s || drain_s) begin
      starve_d = STV_W'(0);
    end else if (pw_s) begin
      if (starve_q < STV_W'(STARVE_LIMIT)) begin
        starve_d = starve_q + STV_W'(1);
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end
    // Built from the next count, so stall_req drops in the cycle after the pop.
    stall_d = !rst && (starve_d >= STV_W'(STARVE_LIMIT));
  end

  // Control registers. The reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    mdu_ready_q <= mdu_ready_d;
    busy_q      <= busy_d;
    starve_q    <= starve_d;
    stall_q     <= stall_d;
  end

  assign mdu_ready = mdu_ready_q;
  assign busy_mask = busy_q;
  assign stall_req = stall_q;

endmodule
